pc_call_stack: RTL and testbench
================================

Name: pc_call_stack

Overview:
- Parametrised successor to the CPU's program counter: a registered instruction-address generator with a hardware return-address stack.
- Supports sequential fetch, absolute jump, call and return, with stall, sticky overflow/underflow error flags and stack occupancy reporting.
- Drives i_addr to instruction memory.
- Jump/call target comes from the data bus path; the control unit drives the command strobes.

Parameters:
- WIDTH, 16, address width in bits; also the width of each stack entry.
- DEPTH, 8, number of return-address stack entries; must be >= 2.
- RESET_ADDR, 0, value loaded into i_addr on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hold all state this cycle; command strobes are ignored.
- increment  input  1  i_addr <= i_addr + 1.
- load  input  1  i_addr <= target.
- call  input  1  push i_addr + 1, then i_addr <= target.
- ret  input  1  pop top of stack into i_addr.
- clear_err  input  1  clear the sticky overflow and underflow flags.
- target  input  WIDTH  jump/call destination.
- i_addr  output  WIDTH  registered instruction address.
- stack_top  output  WIDTH  entry at top of stack; 0 when empty.
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- overflow  output  1  sticky: a call was attempted while full.
- underflow  output  1  sticky: a ret was attempted while empty.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - i_addr = RESET_ADDR; depth = 0; empty = 1; full = 0.
  - overflow = 0; underflow = 0; stack_top = 0.
  - Stack RAM contents are don't-care.
- Reset mid-operation discards any in-flight command and stack contents.
- Command priority per cycle: rst > stall > ret > call > load > increment.
  - Only the highest-priority asserted command takes effect; the rest are ignored with no side effects.
  - With no command asserted, i_addr holds.
- All effects are visible on outputs one cycle after the sampling edge. There is no combinational path from inputs to outputs.
- increment: i_addr + 1 modulo 2^WIDTH; all-ones wraps to 0.
- load: i_addr <= target; the stack is unchanged.
- call, not full: stack[depth] <= i_addr + 1 (mod 2^WIDTH); depth += 1; i_addr <= target.
- call, full: no push, i_addr unchanged, overflow <= 1.
- ret, not empty: i_addr <= stack[depth-1]; depth -= 1.
- ret, empty: i_addr unchanged, underflow <= 1.
- stack_top:
  - Equals stack[depth-1] when depth > 0, else 0.
  - Updates in the same cycle as depth.
- clear_err: clears both flags.
  - If the same cycle also sets a flag (failed call or ret), the set wins.
  - clear_err is honoured even while stall is high.
- stall: i_addr, stack and depth hold. Only clear_err is acted on.
- Stack behaviour is strictly LIFO. The return address is the address after the call instruction.

Test Plan:
1. Reset with RESET_ADDR=0x0100, then 3 cycles of increment -> i_addr 0x0100, 0x0101, 0x0102, 0x0103; depth 0; empty 1.
2. Set i_addr=0x0010, then call target=0x0200 -> i_addr 0x0200, depth 1, stack_top 0x0011. Next, ret -> i_addr 0x0011, depth 0, empty 1.
3. With DEPTH=8, 8 nested calls from addresses 0x10..0x17 -> full 1. A 9th call -> overflow 1, i_addr unchanged, depth 8. Then 8 rets -> i_addr sequence 0x18, 0x17, …, 0x11.
4. ret while empty -> underflow 1, i_addr unchanged. Then clear_err -> underflow 0. Then clear_err together with a ret on an empty stack -> underflow stays 1.
5. Simultaneous strobes:
   - ret+call+load+increment with depth 1 (top 0x0033) -> only ret: i_addr 0x0033.
   - stall+call -> no change in any state.
   - load+increment with target 0x0400 -> i_addr 0x0400.
6. Wrap-around:
   - i_addr=0xFFFF + increment -> 0x0000.
   - i_addr=0xFFFF + call target=0x0050 -> pushes 0x0000.
   - rst asserted while depth=3 -> next cycle depth 0, i_addr RESET_ADDR, flags 0.

Source files
------------

// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack.
// Handles sequential fetch, jump, call/return, stall and sticky stack error flags.
module pc_call_stack #(
   parameter int               WIDTH      = 16,
   parameter int               DEPTH      = 8,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       increment,
   input  logic                       load,
   input  logic                       call,
   input  logic                       ret,
   input  logic                       clear_err,
   input  logic [WIDTH-1:0]           target,
   output logic [WIDTH-1:0]           i_addr,
   output logic [WIDTH-1:0]           stack_top,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] stack_q [DEPTH];

   logic [WIDTH-1:0] i_addr_q, i_addr_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH-1:0] addr_inc;
   logic             is_full, is_empty;
   logic             push, ovf_set, unf_set;
   logic [AW-1:0]    push_idx, top_idx, below_idx;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      i_addr_d  = i_addr_q;
      top_d     = top_q;
      depth_d   = depth_q;
      push      = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;

      addr_inc  = i_addr_q + WIDTH'(1);
      is_full   = (depth_q == DW'(DEPTH));
      is_empty  = (depth_q == '0);
      push_idx  = AW'(depth_q);
      top_idx   = AW'(depth_q - DW'(1));
      below_idx = AW'(depth_q - DW'(2));

      // Priority: ret > call > load > increment; stall blocks all of them.
      if (!stall) begin
         if (ret) begin
            if (is_empty) begin
               unf_set = 1'b1;
            end else begin
               i_addr_d = stack_q[top_idx];
               depth_d  = depth_q - DW'(1);
               top_d    = (depth_q > DW'(1)) ? stack_q[below_idx] : '0;
            end
         end else if (call) begin
            if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               push     = 1'b1;
               depth_d  = depth_q + DW'(1);
               i_addr_d = target;
               top_d    = addr_inc;
            end
         end else if (load) begin
            i_addr_d = target;
         end else if (increment) begin
            i_addr_d = addr_inc;
         end
      end

      // A flag set in the same cycle as clear_err wins.
      ovf_d = (ovf_q & ~clear_err) | ovf_set;
      unf_d = (unf_q & ~clear_err) | unf_set;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_addr_q <= RESET_ADDR;
         top_q    <= '0;
         depth_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         i_addr_q <= i_addr_d;
         top_q    <= top_d;
         depth_q  <= depth_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // NOTE: the stack RAM is not reset; depth_q alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         stack_q[push_idx] <= addr_inc;
      end
   end

   assign i_addr    = i_addr_q;
   assign stack_top = top_q;
   assign depth     = depth_q;
   assign full      = is_full;
   assign empty     = is_empty;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: directed vectors queue expected state,
// a negedge monitor pops and compares after each clock edge.
module tb_pc_call_stack;

   localparam int W = 16;
   localparam int D = 8;

   localparam logic [6:0] RST  = 7'b1000000;
   localparam logic [6:0] STL  = 7'b0100000;
   localparam logic [6:0] RET  = 7'b0010000;
   localparam logic [6:0] CALL = 7'b0001000;
   localparam logic [6:0] LOAD = 7'b0000100;
   localparam logic [6:0] INC  = 7'b0000010;
   localparam logic [6:0] CLR  = 7'b0000001;
   localparam logic [6:0] IDLE = 7'b0000000;

   logic         clk = 1'b0;
   logic         rst, stall, increment, load, call, ret, clear_err;
   logic [W-1:0] target;
   logic [W-1:0] i_addr, stack_top;
   logic [3:0]   depth;
   logic         full, empty, overflow, underflow;

   pc_call_stack #(.WIDTH(W), .DEPTH(D), .RESET_ADDR(16'h0100)) dut (
      .clk(clk), .rst(rst), .stall(stall), .increment(increment), .load(load),
      .call(call), .ret(ret), .clear_err(clear_err), .target(target),
      .i_addr(i_addr), .stack_top(stack_top), .depth(depth), .full(full),
      .empty(empty), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] addr;
      logic [3:0]   dep;
      logic [W-1:0] top;
      logic         ovf;
      logic         unf;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   vec_n = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec %0d: got %h expected %h", name, vec_n, act, exp);
      end
   endtask

   // Monitor: one expectation per clock edge, checked at the following negedge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check("i_addr",    32'(i_addr),    32'(mon_e.addr));
         check("depth",     32'(depth),     32'(mon_e.dep));
         check("stack_top", 32'(stack_top), 32'(mon_e.top));
         check("full",      32'(full),      32'(mon_e.dep == 4'd8));
         check("empty",     32'(empty),     32'(mon_e.dep == 4'd0));
         check("overflow",  32'(overflow),  32'(mon_e.ovf));
         check("underflow", 32'(underflow), 32'(mon_e.unf));
         vec_n++;
      end
   end

   task automatic step(input logic [6:0] cmd, input logic [W-1:0] tgt,
                       input logic [W-1:0] e_addr, input int e_dep,
                       input logic [W-1:0] e_top, input logic e_ovf, input logic e_unf);
      exp_t e;
      {rst, stall, ret, call, load, increment, clear_err} = cmd;
      target = tgt;
      e.addr = e_addr;
      e.dep  = 4'(e_dep);
      e.top  = e_top;
      e.ovf  = e_ovf;
      e.unf  = e_unf;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      {rst, stall, ret, call, load, increment, clear_err} = IDLE;
      target = '0;

      // Reset then sequential fetch
      step(RST,  16'h0000, 16'h0100, 0, 16'h0000, 0, 0);
      step(INC,  16'h0000, 16'h0101, 0, 16'h0000, 0, 0);
      step(INC,  16'h0000, 16'h0102, 0, 16'h0000, 0, 0);
      step(INC,  16'h0000, 16'h0103, 0, 16'h0000, 0, 0);
      step(IDLE, 16'h0000, 16'h0103, 0, 16'h0000, 0, 0);

      // Single call/return
      step(LOAD, 16'h0010, 16'h0010, 0, 16'h0000, 0, 0);
      step(CALL, 16'h0200, 16'h0200, 1, 16'h0011, 0, 0);
      step(RET,  16'h0000, 16'h0011, 0, 16'h0000, 0, 0);

      // Fill the stack from 0x10..0x17, overflow, then unwind
      step(LOAD, 16'h0010, 16'h0010, 0, 16'h0000, 0, 0);
      for (int i = 0; i < 8; i++)
         step(CALL, 16'(16'h0011 + i), 16'(16'h0011 + i), i + 1, 16'(16'h0011 + i), 0, 0);
      step(CALL, 16'h0099, 16'h0018, 8, 16'h0018, 1, 0);
      for (int k = 1; k <= 8; k++)
         step(RET, 16'h0000, 16'(16'h0019 - k), 8 - k,
              (k < 8) ? 16'(16'h0018 - k) : 16'h0000, 1, 0);
      step(CLR,  16'h0000, 16'h0011, 0, 16'h0000, 0, 0);

      // Underflow and clear/set interaction
      step(RET,       16'h0000, 16'h0011, 0, 16'h0000, 0, 1);
      step(CLR,       16'h0000, 16'h0011, 0, 16'h0000, 0, 0);
      step(CLR | RET, 16'h0000, 16'h0011, 0, 16'h0000, 0, 1);
      step(CLR,       16'h0000, 16'h0011, 0, 16'h0000, 0, 0);

      // Simultaneous strobes
      step(LOAD, 16'h0032, 16'h0032, 0, 16'h0000, 0, 0);
      step(CALL, 16'h0500, 16'h0500, 1, 16'h0033, 0, 0);
      step(RET | CALL | LOAD | INC, 16'h0777, 16'h0033, 0, 16'h0000, 0, 0);
      step(CALL, 16'h0600, 16'h0600, 1, 16'h0034, 0, 0);
      step(STL | CALL, 16'h0999, 16'h0600, 1, 16'h0034, 0, 0);
      step(STL | RET | LOAD | INC, 16'h0999, 16'h0600, 1, 16'h0034, 0, 0);
      step(LOAD | INC, 16'h0400, 16'h0400, 1, 16'h0034, 0, 0);
      step(RET,  16'h0000, 16'h0034, 0, 16'h0000, 0, 0);
      step(RET,  16'h0000, 16'h0034, 0, 16'h0000, 0, 1);
      step(STL | CLR, 16'h0000, 16'h0034, 0, 16'h0000, 0, 0);

      // Wrap-around
      step(LOAD, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 0, 0);
      step(INC,  16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
      step(LOAD, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 0, 0);
      step(CALL, 16'h0050, 16'h0050, 1, 16'h0000, 0, 0);
      step(RET,  16'h0000, 16'h0000, 0, 16'h0000, 0, 0);

      // Reset mid-operation with depth 3 and a flag set
      step(RET,  16'h0000, 16'h0000, 0, 16'h0000, 0, 1);
      step(CALL, 16'h0060, 16'h0060, 1, 16'h0001, 0, 1);
      step(CALL, 16'h0070, 16'h0070, 2, 16'h0061, 0, 1);
      step(CALL, 16'h0080, 16'h0080, 3, 16'h0071, 0, 1);
      step(RST | CALL, 16'h0123, 16'h0100, 0, 16'h0000, 0, 0);
      step(INC,  16'h0000, 16'h0101, 0, 16'h0000, 0, 0);
      step(RET,  16'h0000, 16'h0101, 0, 16'h0000, 0, 1);

      {rst, stall, ret, call, load, increment, clear_err} = IDLE;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
